load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/load_store_unit_align.sv | 51 +++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - lsu_access_error(): decides at accept time whether a request faults
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_DATA  = 3'd2,
      WR       = 3'd3,
      RESP     = 3'd4
   } lsu_state_e;

   // A request faults on misalignment, an encoding with no RV32I meaning,
   // an unsigned store (no such instruction) or a word index past the memory.
   function automatic logic lsu_access_error(input logic        write,
                                             input logic [2:0]  funct3,
                                             input logic [31:0] addr,
                                             input int unsigned mem_words);
      logic err;
      err = 1'b0;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_BU:   err = write;
         F3_H:    err = addr[0];
         F3_HU:   err = write | addr[0];
         F3_W:    err = |addr[1:0];
         default: err = 1'b1;
      endcase
      if ({2'b00, addr[31:2]} >= 32'(mem_words)) err = 1'b1;
      return err;
   endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational byte/half steering for the load/store unit.
//   word        in  32  word read from memory
//   offset      in  2   byte offset within the word (addr[1:0])
//   funct3      in  3   access size / signedness
//   wdata       in  32  store data (low byte/half used for SB/SH)
//   load_data   out 32  selected lane, sign- or zero-extended
//   merged_word out 32  word with the store lane replaced (SB/SH), else wdata
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [4:0]  bit_base;

   assign bit_base = {offset, 3'b000};

   always_comb begin
      byte_sel = word[bit_base +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data = {24'd0, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data = {16'd0, half_sel};
         default: load_data = word;
      endcase
   end

   // Memory has no byte enables, so sub-word stores rebuild the full word.
   always_comb begin
      merged_word = word;
      if (funct3 == F3_B) begin
         merged_word[bit_base +: 8] = wdata[7:0];
      end else if (funct3 == F3_H) begin
         if (offset[1]) merged_word[31:16] = wdata[15:0];
         else           merged_word[15:0]  = wdata[15:0];
      end else begin
         merged_word = wdata;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a word-addressed memory
// with a registered read port and a single word write-enable.
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only when idle)
//   req_write            1 = store, 0 = load
//   req_funct3           RV32I size/sign encoding
//   req_addr, req_wdata  byte address and store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores/errors)
//   resp_error           fault flag, qualified by resp_valid
//   mem_address          word-aligned byte address to memory
//   mem_write_data       full word to write
//   mem_write_enable     write strobe, high for the WR cycle only
//   mem_read_data        word addressed on the previous edge
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data
);

   lsu_state_e  state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  offset_q, offset_d;
   logic [31:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_we_q, mem_we_d;

   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic        acc_err;

   lsu_align u_align (
      .word        (mem_read_data),
      .offset      (offset_q),
      .funct3      (funct3_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   assign acc_err = lsu_access_error(req_write, req_funct3, req_addr, MEM_WORDS);

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      funct3_d     = funct3_q;
      offset_d     = offset_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      // Strobes and response fields default low so each is a single-cycle
      // pulse set only on the transition into the cycle that presents it.
      mem_we_d     = 1'b0;
      resp_valid_d = 1'b0;
      resp_error_d = 1'b0;
      resp_rdata_d = 32'd0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               funct3_d   = req_funct3;
               offset_d   = req_addr[1:0];
               wdata_d    = req_wdata;
               mem_addr_d = {req_addr[31:2], 2'b00};
               if (acc_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end else if (req_write && req_funct3 == F3_W) begin
                  // Full-word store needs no read: write straight away.
                  state_d     = WR;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d = RD_ISSUE;
               end
            end
         end

         // Memory captures mem_address on the edge ending this cycle.
         RD_ISSUE: state_d = RD_DATA;

         RD_DATA: begin
            if (write_q) begin
               state_d     = WR;
               mem_we_d    = 1'b1;
               mem_wdata_d = merged_word;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end
         end

         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end

         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'd0;
         offset_q     <= 2'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         funct3_q     <= funct3_d;
         offset_q     <= offset_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
      end
   end

   assign req_ready        = (state_q == IDLE);
   assign resp_valid       = resp_valid_q;
   assign resp_error       = resp_error_q;
   assign resp_rdata       = resp_rdata_q;
   assign mem_address      = mem_addr_q;
   assign mem_write_data   = mem_wdata_q;
   assign mem_write_enable = mem_we_q;

endmodule
